// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for a 4-digit, 8-bit segment display. Keeps a committed
//   bank of four digit patterns (buf0..buf3) that feeds an external 4-to-1
//   segment mux, and drives the mux select and the active-low digit anodes.
//   Each digit slot is SCAN_DIV cycles long and begins with BLANK_CYC cycles
//   with all anodes off. New patterns arrive through a req/ack handshake into
//   a pending bank. That bank is committed only on the last edge of a frame,
//   so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   upd_req     update request (level, held until upd_ack)
//   d0..d3      new segment patterns for digits 0..3 (active-low segments)
//   dig_en_in   new per-digit enable mask
//   blink       per-digit blink enable (only with SEG_SCAN_BLINK_EN)
//   upd_ack     one-cycle pulse: update captured into the pending bank
//   buf0..buf3  committed patterns, to mux inputs I0..I3
//   sel         mux select / current digit index
//   an          digit anodes, active-low
//   frame_done  one-cycle pulse in the last cycle of slot 3
//
// Optional feature
//   SEG_SCAN_BLINK_EN adds the blink input and the BLINK_FRAMES parameter.
//   A frame counter toggles a blink phase every BLINK_FRAMES frames. While
//   the phase is 1, digits with blink set stay dark.
//
// FSM states
//   state | meaning
//   BLANK | cnt < BLANK_CYC, all anodes off (anti-ghosting)
//   DRIVE | cnt >= BLANK_CYC, anode of digit sel on if enabled

module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_req,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [3:0] dig_en_in,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [3:0] blink,
`endif
  output logic       upd_ack,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FCNT_ONE = FW'(1);
`endif

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    en_mask;
  logic [3:0]    mask_nxt;
  logic [3:0]    an_nxt;
  logic          fd_nxt;
  logic          wrap;
  logic          commit;
  logic          capture;

  logic          pend_valid;
  logic [7:0]    pend_d0;
  logic [7:0]    pend_d1;
  logic [7:0]    pend_d2;
  logic [7:0]    pend_d3;
  logic [3:0]    pend_en;

`ifdef SEG_SCAN_BLINK_EN
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic          phase;
  logic          phase_nxt;
`endif

  // Next-state values are computed here so that an, sel, cnt and frame_done
  // are all registered and move together on the same edge.
  always_comb begin
    wrap     = (cnt == CNT_MAX);
    cnt_nxt  = wrap ? '0 : cnt + CNT_ONE;
    sel_nxt  = wrap ? sel + 2'd1 : sel;
    // A commit happens on the frame's last edge, so the new mask first
    // lands while slot 0 is still blanked.
    commit   = wrap && (sel == 2'd3) && pend_valid;
    // While pending is valid (including the commit edge) requests wait.
    capture  = upd_req && !pend_valid;
    mask_nxt = commit ? pend_en : en_mask;
    fd_nxt   = (sel_nxt == 2'd3) && (cnt_nxt == CNT_MAX);

    state_nxt = state;
    case (state)
      BLANK:   if (cnt_nxt == CNT_BLANK) state_nxt = DRIVE;
      DRIVE:   if (wrap) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

`ifdef SEG_SCAN_BLINK_EN
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    if (wrap && (sel == 2'd3)) begin
      if (fcnt == FCNT_MAX) begin
        fcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        fcnt_nxt = fcnt + FCNT_ONE;
      end
    end
`endif

    an_nxt = 4'b1111;
    if ((state_nxt == DRIVE) && mask_nxt[sel_nxt]) begin
      an_nxt[sel_nxt] = 1'b0;
    end
`ifdef SEG_SCAN_BLINK_EN
    if (blink[sel_nxt] && phase_nxt) begin
      an_nxt[sel_nxt] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      sel        <= 2'd0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
      en_mask    <= 4'b0000;
      buf0       <= 8'hFF;
      buf1       <= 8'hFF;
      buf2       <= 8'hFF;
      buf3       <= 8'hFF;
      pend_valid <= 1'b0;
      pend_d0    <= 8'hFF;
      pend_d1    <= 8'hFF;
      pend_d2    <= 8'hFF;
      pend_d3    <= 8'hFF;
      pend_en    <= 4'b0000;
`ifdef SEG_SCAN_BLINK_EN
      fcnt       <= '0;
      phase      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      an         <= an_nxt;
      frame_done <= fd_nxt;
      upd_ack    <= capture;
      en_mask    <= mask_nxt;
`ifdef SEG_SCAN_BLINK_EN
      fcnt       <= fcnt_nxt;
      phase      <= phase_nxt;
`endif
      if (commit) begin
        buf0       <= pend_d0;
        buf1       <= pend_d1;
        buf2       <= pend_d2;
        buf3       <= pend_d3;
        pend_valid <= 1'b0;
      end else if (capture) begin
        pend_d0    <= d0;
        pend_d1    <= d1;
        pend_d2    <= d2;
        pend_d3    <= d3;
        pend_en    <= dig_en_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller for the 4-digit, 8-bit segment display path. Holds a double-buffered bank of four digit patterns, presents them on buf0..buf3 to the 4-to-1 8-bit segment multiplexer, and drives that mux's 2-bit select together with the digit anodes.
Each digit slot starts with a blanking interval to suppress ghosting. New display data comes in through a req/ack handshake and is committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; legal range SCAN_DIV >= BLANK_CYC+2.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; legal range BLANK_CYC >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
upd_req  in  1  update request, level; held by requester until upd_ack
d0, d1, d2, d3  in  8 each  new segment patterns for digits 0..3 (active-low segments)
dig_en_in  in  4  new per-digit enable mask
upd_ack  out  1  one-cycle pulse: update captured
buf0, buf1, buf2, buf3  out  8 each  committed patterns, to mux I0..I3
sel  out  2  mux select / current digit index
an  out  4  digit anodes, active-low
frame_done  out  1  one-cycle pulse at end of slot 3

Behaviour:
- Reset values, applied on any clk edge with rst=1, including mid-frame or mid-handshake:
  - sel=0, an=4'b1111, buf0..3=8'hFF, committed enable mask=4'b0000.
  - pending bank invalid, upd_ack=0, frame_done=0.
  - slot counter=0, state=BLANK.
  - A pending update that was not yet committed is discarded.
- Slot counter cnt counts 0..SCAN_DIV-1, width $clog2(SCAN_DIV). At cnt=SCAN_DIV-1, cnt wraps to 0 and sel advances 0->1->2->3->0 (2-bit wrap).
- FSM, two states:
  - BLANK (cnt < BLANK_CYC): an=4'b1111.
  - DRIVE (cnt >= BLANK_CYC): an[sel]=0 if committed enable[sel]=1; all other an bits are 1.
  - BLANK->DRIVE when cnt reaches BLANK_CYC. DRIVE->BLANK on wrap.
  - an is registered: it changes on the same edge as cnt/sel. The mux data never changes while an is active.
- frame_done is high for the single cycle where sel=3 and cnt=SCAN_DIV-1. On that same edge:
  - If pending is valid: pending d0..d3 -> buf0..buf3, pending mask -> committed mask, pending becomes invalid.
  - Otherwise buf0..3 and the committed mask hold.
- Capture handshake:
  - On an edge where upd_req=1 and pending is invalid, d0..d3 and dig_en_in are latched into pending, pending becomes valid, and upd_ack=1 for the next cycle only.
  - While pending is valid, upd_req is ignored and no ack is issued.
  - A requester must drop upd_req in the cycle upd_ack is seen. If upd_req is still high once pending is invalid again, that is a new request.
- Simultaneous commit and request: on the commit edge pending is still valid, so the request is not captured. It is accepted on the following edge, and that data shows one frame later.
- Latency:
  - Request to upd_ack: 1 cycle.
  - Capture to visible: committed at the next frame_done edge; first driven in the DRIVE phase of slot 0 of the following frame.
- buf0..3 change only at frame boundaries. sel never skips a value.

Optional Feature:
Macro SEG_SCAN_BLINK_EN. When defined:
- Adds input blink (4 bits, per digit) and parameter BLINK_FRAMES (default 64).
- A frame counter toggles a blink phase bit every BLINK_FRAMES frame_done pulses. Reset clears both the frame counter and the phase to 0.
- In DRIVE, an[sel] is forced to 1 when blink[sel]=1 and phase=1.

When undefined: no blink port, no frame counter, and behaviour is exactly as above.

Test Plan:
1. SCAN_DIV=8, BLANK_CYC=2, reset release, no update -> an=1111 throughout (mask 0); sel sequence 0,1,2,3 each held 8 cycles; frame_done pulses every 32 cycles at sel=3, cnt=7.
2. Pulse upd_req with d0..3=8'hC0,F9,A4,B0 and mask 1111 mid-frame -> upd_ack one cycle later; buf unchanged until frame_done edge, then buf0..3=C0,F9,A4,B0; next frame an=1110 in DRIVE of slot 0, cycles 2..7; an=1111 on cycles 0..1.
3. Hold upd_req high after ack while pending valid -> no second ack until commit; second capture on the edge after frame_done; its data displayed one frame later.
4. Request asserted exactly in the frame_done cycle with pending valid -> old pending committed; new request acked 2 cycles later; the new data does not appear in the very next frame.
5. Mask 0101 -> an low only in slots 0 and 2 during DRIVE; slots 1 and 3 stay 1111.
6. Assert rst during DRIVE of slot 2 with pending valid -> next cycle sel=0, an=1111, buf=FF, pending discarded, no upd_ack; with SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink=0001 -> digit 0 dark on frames 2-3, 6-7.
